// File: rtl/channel_ctl_pkg.sv
// Shared types for the LED channel controller: SPI command codes, decoder
// states and configuration register indices.
package channel_ctl_pkg;

  typedef enum logic [7:0] {
    CMD_CONF_WR = 8'h2A,
    CMD_ADDR_WR = 8'h2B,
    CMD_DATA_WR = 8'h2C,
    CMD_CONF_RD = 8'h2D
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONF_WR = 3'd1,
    ST_CONF_RD = 3'd2,
    ST_ADDR_WR = 3'd3,
    ST_DATA_WR = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [2:0] REG_T0H      = 3'd0;
  localparam logic [2:0] REG_T0L      = 3'd1;
  localparam logic [2:0] REG_T1H      = 3'd2;
  localparam logic [2:0] REG_T1L      = 3'd3;
  localparam logic [2:0] REG_CHAN_LEN = 3'd4;
  localparam logic [2:0] REG_CHAN_CNT = 3'd5;
  localparam logic [2:0] NUM_REGS     = 3'd6;

endpackage

// File: rtl/led_regfile.sv
// Six 8-bit timing/geometry registers with a combinational read port.
// Addresses 6 and 7 read as zero and drop writes.
module led_regfile
  import channel_ctl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [2:0] rd_addr_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] rd_data_o,
  output logic [7:0] t0h_o,
  output logic [7:0] t0l_o,
  output logic [7:0] t1h_o,
  output logic [7:0] t1l_o,
  output logic [7:0] chan_len_o,
  output logic [3:0] chan_cnt_o
);

  logic [7:0] t0h_q, t0l_q, t1h_q, t1l_q, chan_len_q;
  logic [3:0] chan_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      t0h_q      <= 8'h00;
      t0l_q      <= 8'h00;
      t1h_q      <= 8'h00;
      t1l_q      <= 8'h00;
      chan_len_q <= 8'h00;
      chan_cnt_q <= 4'h0;
    end else if (wr_en_i) begin
      case (wr_addr_i)
        REG_T0H:      t0h_q      <= wr_data_i;
        REG_T0L:      t0l_q      <= wr_data_i;
        REG_T1H:      t1h_q      <= wr_data_i;
        REG_T1L:      t1l_q      <= wr_data_i;
        REG_CHAN_LEN: chan_len_q <= wr_data_i;
        REG_CHAN_CNT: chan_cnt_q <= wr_data_i[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data_o = 8'h00;
    case (rd_addr_i)
      REG_T0H:      rd_data_o = t0h_q;
      REG_T0L:      rd_data_o = t0l_q;
      REG_T1H:      rd_data_o = t1h_q;
      REG_T1L:      rd_data_o = t1l_q;
      REG_CHAN_LEN: rd_data_o = chan_len_q;
      REG_CHAN_CNT: rd_data_o = {4'h0, chan_cnt_q};
      default: ;
    endcase
  end

  assign t0h_o      = t0h_q;
  assign t0l_o      = t0l_q;
  assign t1h_o      = t1h_q;
  assign t1l_o      = t1l_q;
  assign chan_len_o = chan_len_q;
  assign chan_cnt_o = chan_cnt_q;

endmodule

// File: rtl/led_channel_ctl.sv
// SPI byte-stream decoder: command FSM, config register access and LED RAM
// write sequencing. Define CHANNEL_CTL_CONF_RD_EN to enable register readback.
// Handshake: spi_byte_vld_i is a single-cycle strobe with no back-pressure;
// every strobed byte is consumed in its cycle and any RAM write it causes
// appears on the ram_wr_* outputs for exactly the following cycle.
module led_channel_ctl
  import channel_ctl_pkg::*;
#(
  parameter int CHAN_NUM = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                dc_i,
  input  logic                spi_byte_vld_i,
  input  logic [7:0]          spi_byte_data_i,
  output logic [7:0]          reg_rd_data_o,
  output logic [7:0]          reg_t0h_o,
  output logic [7:0]          reg_t0l_o,
  output logic [7:0]          reg_t1h_o,
  output logic [7:0]          reg_t1l_o,
  output logic [7:0]          reg_chan_len_o,
  output logic [3:0]          reg_chan_cnt_o,
  output logic [CHAN_NUM-1:0] ram_wr_en_o,
  output logic [ADDR_W-1:0]   ram_wr_addr_o,
  output logic [3:0]          ram_wr_byte_en_o,
  output logic [7:0]          ram_wr_data_o,
  output logic                ram_wr_done_o,
  output logic [2:0]          dbg_state_o
);

  state_e              state_q, state_d;
  logic [1:0]          lane_q;
  logic [ADDR_W-1:0]   led_q;
  logic [3:0]          chan_q;
  logic [2:0]          wr_idx_q;
  logic [CHAN_NUM-1:0] wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [3:0]          wr_be_q;
  logic [7:0]          wr_data_q;
  logic                done_q;
  logic [2:0]          rd_addr;

  logic cmd_vld, data_vld, lane_last, led_last, chan_last, frame_last;

  assign cmd_vld    = spi_byte_vld_i & ~dc_i;
  assign data_vld   = spi_byte_vld_i & dc_i;
  assign lane_last  = (state_q == ST_ADDR_WR) || (lane_q == 2'd2);
  assign led_last   = (led_q == ADDR_W'(reg_chan_len_o));
  assign chan_last  = (chan_q == reg_chan_cnt_o);
  assign frame_last = lane_last && led_last && chan_last;

  always_comb begin
    state_d = ST_IDLE;
    case (spi_byte_data_i)
      CMD_CONF_WR: state_d = ST_CONF_WR;
      CMD_ADDR_WR: state_d = ST_ADDR_WR;
      CMD_DATA_WR: state_d = ST_DATA_WR;
`ifdef CHANNEL_CTL_CONF_RD_EN
      CMD_CONF_RD: state_d = ST_CONF_RD;
`endif
      default: ;
    endcase
  end

`ifdef CHANNEL_CTL_CONF_RD_EN
  logic [2:0] rd_ptr_q;
  assign rd_addr = rd_ptr_q;
`else
  // Unmapped address 6 always reads zero, so readback is constant 0x00.
  assign rd_addr = 3'd6;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      lane_q    <= 2'd0;
      led_q     <= '0;
      chan_q    <= 4'd0;
      wr_idx_q  <= 3'd0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_be_q   <= 4'd0;
      wr_data_q <= 8'h00;
      done_q    <= 1'b0;
`ifdef CHANNEL_CTL_CONF_RD_EN
      rd_ptr_q  <= 3'd0;
`endif
    end else begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_be_q   <= 4'd0;
      wr_data_q <= 8'h00;
      done_q    <= 1'b0;
      if (cmd_vld) begin
        state_q  <= state_d;
        lane_q   <= 2'd0;
        led_q    <= '0;
        chan_q   <= 4'd0;
        wr_idx_q <= 3'd0;
`ifdef CHANNEL_CTL_CONF_RD_EN
        rd_ptr_q <= 3'd0;
`endif
      end else if (data_vld) begin
        case (state_q)
          ST_CONF_WR: if (wr_idx_q != NUM_REGS) wr_idx_q <= wr_idx_q + 3'd1;
`ifdef CHANNEL_CTL_CONF_RD_EN
          ST_CONF_RD: rd_ptr_q <= rd_ptr_q + 3'd1;
`endif
          ST_ADDR_WR, ST_DATA_WR: begin
            wr_en_q   <= CHAN_NUM'(1) << chan_q;
            wr_addr_q <= led_q;
            wr_be_q   <= (state_q == ST_ADDR_WR) ? 4'b1000 : (4'b0001 << lane_q);
            wr_data_q <= spi_byte_data_i;
            done_q    <= frame_last && (state_q == ST_DATA_WR);
            // Lane is innermost, then LED, then channel; each wraps on carry.
            if (!lane_last) begin
              lane_q <= lane_q + 2'd1;
            end else begin
              lane_q <= 2'd0;
              if (!led_last) begin
                led_q <= led_q + 1'b1;
              end else begin
                led_q <= '0;
                if (!chan_last) begin
                  chan_q <= chan_q + 4'd1;
                end else begin
                  chan_q  <= 4'd0;
                  state_q <= ST_DONE;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  led_regfile u_regfile (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rd_addr_i  (rd_addr),
    .wr_en_i    (data_vld && (state_q == ST_CONF_WR) && (wr_idx_q < NUM_REGS)),
    .wr_addr_i  (wr_idx_q),
    .wr_data_i  (spi_byte_data_i),
    .rd_data_o  (reg_rd_data_o),
    .t0h_o      (reg_t0h_o),
    .t0l_o      (reg_t0l_o),
    .t1h_o      (reg_t1h_o),
    .t1l_o      (reg_t1l_o),
    .chan_len_o (reg_chan_len_o),
    .chan_cnt_o (reg_chan_cnt_o)
  );

  assign ram_wr_en_o      = wr_en_q;
  assign ram_wr_addr_o    = wr_addr_q;
  assign ram_wr_byte_en_o = wr_be_q;
  assign ram_wr_data_o    = wr_data_q;
  assign ram_wr_done_o    = done_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_led_channel_ctl.sv
// Self-checking bench for led_channel_ctl: RAM writes are checked against an
// expected queue filled as bytes are driven.
module tb_led_channel_ctl;
  import channel_ctl_pkg::*;

  localparam int W = 37;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        dc_i = 1'b0;
  logic        spi_byte_vld_i = 1'b0;
  logic [7:0]  spi_byte_data_i = 8'h00;
  logic [7:0]  reg_rd_data_o, reg_t0h_o, reg_t0l_o, reg_t1h_o, reg_t1l_o, reg_chan_len_o;
  logic [3:0]  reg_chan_cnt_o;
  logic [15:0] ram_wr_en_o;
  logic [7:0]  ram_wr_addr_o;
  logic [3:0]  ram_wr_byte_en_o;
  logic [7:0]  ram_wr_data_o;
  logic        ram_wr_done_o;
  logic [2:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] cfg_vals [6] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h3F, 8'h07};

  led_channel_ctl dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .dc_i             (dc_i),
    .spi_byte_vld_i   (spi_byte_vld_i),
    .spi_byte_data_i  (spi_byte_data_i),
    .reg_rd_data_o    (reg_rd_data_o),
    .reg_t0h_o        (reg_t0h_o),
    .reg_t0l_o        (reg_t0l_o),
    .reg_t1h_o        (reg_t1h_o),
    .reg_t1l_o        (reg_t1l_o),
    .reg_chan_len_o   (reg_chan_len_o),
    .reg_chan_cnt_o   (reg_chan_cnt_o),
    .ram_wr_en_o      (ram_wr_en_o),
    .ram_wr_addr_o    (ram_wr_addr_o),
    .ram_wr_byte_en_o (ram_wr_byte_en_o),
    .ram_wr_data_o    (ram_wr_data_o),
    .ram_wr_done_o    (ram_wr_done_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Scoreboard: every observed write (or done pulse) must match the queue head.
  always @(negedge clk_i) begin
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    if (ram_wr_en_o != 16'h0 || ram_wr_done_o) begin
      obs = {ram_wr_en_o, ram_wr_addr_o, ram_wr_byte_en_o, ram_wr_data_o, ram_wr_done_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write_unexpected: got en=%h addr=%h be=%b data=%h done=%b, required no write",
                 ram_wr_en_o, ram_wr_addr_o, ram_wr_byte_en_o, ram_wr_data_o, ram_wr_done_o);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          errors++;
          $display("FAIL ram_write: got en=%h addr=%h be=%b data=%h done=%b, required en=%h addr=%h be=%b data=%h done=%b",
                   obs[36:21], obs[20:13], obs[12:9], obs[8:1], obs[0],
                   exp[36:21], exp[20:13], exp[12:9], exp[8:1], exp[0]);
        end
      end
    end
  end

  // Driver tasks (called at a negedge; return at the next negedge)
  task automatic send_byte(input logic dc, input logic [7:0] b, output logic [7:0] rd);
    spi_byte_vld_i  = 1'b1;
    dc_i            = dc;
    spi_byte_data_i = b;
    #1 rd = reg_rd_data_o;
    @(negedge clk_i);
    spi_byte_vld_i  = 1'b0;
    dc_i            = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [7:0] rd;
    send_byte(1'b0, c, rd);
  endtask

  task automatic send_data(input logic [7:0] b);
    logic [7:0] rd;
    send_byte(1'b1, b, rd);
  endtask

  task automatic push_wr(input int chan, input int addr, input logic [3:0] be,
                         input logic [7:0] data, input logic done);
    logic [15:0] en;
    en = 16'h0001 << chan;
    exp_q.push_back({en, 8'(addr), be, data, done});
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d writes outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  function automatic logic [7:0] get_reg(input int k);
    case (k)
      0: return reg_t0h_o;
      1: return reg_t0l_o;
      2: return reg_t1h_o;
      3: return reg_t1l_o;
      4: return reg_chan_len_o;
      default: return {4'h0, reg_chan_cnt_o};
    endcase
  endfunction

  task automatic write_config(input logic [7:0] len, input logic [7:0] cnt);
    send_cmd(8'h2A);
    for (int k = 0; k < 4; k++) send_data(cfg_vals[k]);
    send_data(len);
    send_data(cnt);
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++;
    if ({ram_wr_en_o, ram_wr_done_o, reg_rd_data_o} !== 25'h0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%h done=%b rd=%h, required 0", ram_wr_en_o, ram_wr_done_o, reg_rd_data_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({reg_t0h_o, reg_t0l_o, reg_t1h_o, reg_t1l_o, reg_chan_len_o, reg_chan_cnt_o} !== 44'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h %h %h %h %h %h, required all 0",
               reg_t0h_o, reg_t0l_o, reg_t1h_o, reg_t1l_o, reg_chan_len_o, reg_chan_cnt_o);
    end
    checks++;
    if (dbg_state_o !== 3'(ST_IDLE)) begin
      errors++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state_o, ST_IDLE);
    end
    send_data(8'h99);
    drain("reset_idle");
  endtask

  task automatic test_conf_wr();
    send_cmd(8'h2A);
    for (int k = 0; k < 6; k++) begin
      send_data(cfg_vals[k]);
      checks++;
      if (get_reg(k) !== cfg_vals[k]) begin
        errors++;
        $display("FAIL conf_wr_reg%0d: got %h, required %h", k, get_reg(k), cfg_vals[k]);
      end
    end
    send_data(8'hAA);
    send_data(8'h55);
    checks++;
    if ({reg_t0h_o, reg_t0l_o, reg_t1h_o, reg_t1l_o, reg_chan_len_o, reg_chan_cnt_o} !== 44'h01_12_23_34_3F_7) begin
      errors++;
      $display("FAIL conf_wr_extra: got %h %h %h %h %h %h, required 01 12 23 34 3f 7",
               reg_t0h_o, reg_t0l_o, reg_t1h_o, reg_t1l_o, reg_chan_len_o, reg_chan_cnt_o);
    end
    drain("conf_wr");
  endtask

  task automatic test_conf_rd();
    logic [7:0] rd;
    logic [7:0] exp;
    send_cmd(8'h2D);
    for (int i = 0; i < 16; i++) begin
      send_byte(1'b1, 8'h00, rd);
`ifdef CHANNEL_CTL_CONF_RD_EN
      exp = ((i % 8) < 6) ? cfg_vals[i % 8] : 8'h00;
`else
      exp = 8'h00;
`endif
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL conf_rd_byte%0d: got %h, required %h", i, rd, exp);
      end
    end
    drain("conf_rd");
  endtask

  task automatic test_addr_stream();
    send_cmd(8'h2B);
    for (int i = 0; i < 512; i++) begin
      push_wr(i / 64, i % 64, 4'b1000, i[7:0], 1'b0);
      send_data(i[7:0]);
    end
    send_data(8'hEE);
    checks++;
    if (dbg_state_o !== 3'(ST_DONE)) begin
      errors++;
      $display("FAIL addr_stream_done_state: got %0d, required %0d", dbg_state_o, ST_DONE);
    end
    drain("addr_stream");
  endtask

  task automatic test_data_stream();
    logic [7:0] b;
    send_cmd(8'h2C);
    for (int j = 0; j < 1536; j++) begin
      b = 8'($urandom_range(0, 255));
      push_wr(j / 192, (j % 192) / 3, 4'b0001 << (j % 3), b, j == 1535);
      send_data(b);
    end
    send_data(8'h77);
    drain("data_stream");
  endtask

  task automatic test_abort();
    send_cmd(8'h2C);
    for (int j = 0; j < 10; j++) begin
      push_wr(0, j / 3, 4'b0001 << (j % 3), 8'(j + 8'h40), 1'b0);
      send_data(8'(j + 8'h40));
    end
    send_cmd(8'h55);
    checks++;
    if (dbg_state_o !== 3'(ST_IDLE)) begin
      errors++;
      $display("FAIL abort_state: got %0d, required %0d", dbg_state_o, ST_IDLE);
    end
    for (int j = 0; j < 3; j++) send_data(8'hC0);
    send_cmd(8'h2C);
    for (int j = 0; j < 3; j++) begin
      push_wr(0, 0, 4'b0001 << j, 8'(8'hD0 + j), 1'b0);
      send_data(8'(8'hD0 + j));
    end
    drain("abort");
  endtask

  task automatic test_boundary();
    logic [7:0] b;
    // Single LED, single channel: done on the third byte.
    write_config(8'h00, 8'h00);
    send_cmd(8'h2C);
    for (int j = 0; j < 3; j++) begin
      push_wr(0, 0, 4'b0001 << j, 8'(8'hA0 + j), j == 2);
      send_data(8'(8'hA0 + j));
    end
    send_data(8'hFF);
    drain("min_geometry");
    // All sixteen channels, one LED each, back-to-back bytes.
    write_config(8'h00, 8'h0F);
    send_cmd(8'h2C);
    for (int j = 0; j < 48; j++) begin
      b = 8'($urandom_range(0, 255));
      push_wr(j / 3, 0, 4'b0001 << (j % 3), b, j == 47);
      send_data(b);
    end
    send_data(8'h11);
    drain("max_channels");
  endtask

  task automatic test_reset_mid();
    send_cmd(8'h2C);
    for (int j = 0; j < 4; j++) begin
      push_wr(j / 3, 0, 4'b0001 << (j % 3), 8'(8'h60 + j), 1'b0);
      send_data(8'(8'h60 + j));
    end
    spi_byte_vld_i  = 1'b1;
    dc_i            = 1'b1;
    spi_byte_data_i = 8'h5A;
    @(posedge clk_i);
    #1;
    spi_byte_vld_i = 1'b0;
    checks++;
    if (ram_wr_en_o !== 16'h0002) begin
      errors++;
      $display("FAIL reset_mid_pre_write: got en=%h, required 0002", ram_wr_en_o);
    end
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({ram_wr_en_o, ram_wr_addr_o, ram_wr_byte_en_o, ram_wr_data_o, ram_wr_done_o, reg_rd_data_o} !== 45'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got en=%h addr=%h be=%b data=%h done=%b rd=%h, required 0",
               ram_wr_en_o, ram_wr_addr_o, ram_wr_byte_en_o, ram_wr_data_o, ram_wr_done_o, reg_rd_data_o);
    end
    checks++;
    if ({reg_t0h_o, reg_t0l_o, reg_t1h_o, reg_t1l_o, reg_chan_len_o, reg_chan_cnt_o} !== 44'h0) begin
      errors++;
      $display("FAIL reset_mid_regs: got %h %h %h %h %h %h, required all 0",
               reg_t0h_o, reg_t0l_o, reg_t1h_o, reg_t1l_o, reg_chan_len_o, reg_chan_cnt_o);
    end
    exp_q.delete();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    send_data(8'h33);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_conf_wr();
    test_conf_rd();
    test_addr_stream();
    test_data_stream();
    test_abort();
    test_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
